// File: rtl/float_operand_loader_pkg.sv
// Shared types and constants for the float operand loader.
package float_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        VALID  = 2'd2
    } loader_state_t;

    // Operand width in bytes. Only 4 is supported (single precision).
    localparam int BYTES_PER_WORD = 4;

    // Exponent value shared by NaN and Inf encodings.
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

endpackage

// File: rtl/float_operand_loader_if.sv
// Operand hand-off bus between the loader (master) and the FP datapath (slave).
// Optional macro: FLOAT_LOADER_SPECIAL_CHECK_EN adds the special_flag signal.
interface float_operand_loader_if;

    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        operands_valid;
    logic        operands_ready;
`ifdef FLOAT_LOADER_SPECIAL_CHECK_EN
    logic        special_flag;
`endif

    modport master (
        output operand_a,
        output operand_b,
        output operands_valid,
`ifdef FLOAT_LOADER_SPECIAL_CHECK_EN
        output special_flag,
`endif
        input  operands_ready
    );

    modport slave (
        input  operand_a,
        input  operand_b,
        input  operands_valid,
`ifdef FLOAT_LOADER_SPECIAL_CHECK_EN
        input  special_flag,
`endif
        output operands_ready
    );

endinterface

// File: rtl/float_operand_loader_debouncer.sv
// Key debouncer: 2-flop synchronizer plus saturating low-sample counter.
// Emits a single-cycle press_pulse per press; the key must be seen released
// before another pulse can occur.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic nkey,
    output logic press_pulse
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the raw key into the clock domain; resets to "released".
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= nkey;
            sync2 <= sync1;
        end
    end

    // Count consecutive low samples; pulse on the step that reaches the limit.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sync2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt         <= cnt + CNT_W'(1);
                press_pulse <= (cnt == CNT_ARM);
            end
        end
    end

endmodule

// File: rtl/float_operand_loader.sv
// Assembles two little-endian 32-bit operands from debounced byte entry and
// offers them downstream over a valid/ready handshake.
// Optional macro: FLOAT_LOADER_SPECIAL_CHECK_EN builds the NaN/Inf flag.
//
// state  | meaning
// LOAD_A | collecting operand A bytes, slot = idx
// LOAD_B | collecting operand B bytes, slot = idx
// VALID  | both operands held, waiting for operands_ready
module float_operand_loader
    import float_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          nenter,
    input  logic [7:0]                    inputdata,
    output logic [2:0]                    byte_index,
    float_operand_loader_if.master        bus
);

    localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_WORD - 1);

    loader_state_t state;
    logic [1:0]    idx;
    logic [31:0]   operand_a_q;
    logic [31:0]   operand_b_q;
    logic [31:0]   operand_a_next;
    logic [31:0]   operand_b_next;
    logic          valid_q;
    logic          press_pulse;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_debouncer (
        .clk        (clk),
        .nreset     (nreset),
        .nkey       (nenter),
        .press_pulse(press_pulse)
    );

    // Operand words with the current switch byte merged into slot idx.
    always_comb begin
        operand_a_next = operand_a_q;
        operand_b_next = operand_b_q;
        operand_a_next[{idx, 3'b000} +: 8] = inputdata;
        operand_b_next[{idx, 3'b000} +: 8] = inputdata;
    end

    // Entry sequencer: byte writes, slot advance and the downstream handshake.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= LOAD_A;
            idx         <= 2'd0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (press_pulse) begin
                        operand_a_q <= operand_a_next;
                        idx         <= idx + 2'd1;
                        if (idx == LAST_SLOT) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press_pulse) begin
                        operand_b_q <= operand_b_next;
                        idx         <= idx + 2'd1;
                        if (idx == LAST_SLOT) begin
                            state   <= VALID;
                            valid_q <= 1'b1;
                        end
                    end
                end
                VALID: begin
                    // Presses are ignored here, including one coinciding with the transfer.
                    if (bus.operands_ready) begin
                        state   <= LOAD_A;
                        idx     <= 2'd0;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= LOAD_A;
                    idx     <= 2'd0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FLOAT_LOADER_SPECIAL_CHECK_EN
    logic special_q;

    // Flag NaN/Inf exponents, computed on the final B write so it rises with valid.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            special_q <= 1'b0;
        end else if (state == LOAD_B && press_pulse && idx == LAST_SLOT) begin
            special_q <= (operand_a_q[30:23] == EXP_ALL_ONES) |
                         (operand_b_next[30:23] == EXP_ALL_ONES);
        end else if (state != VALID || bus.operands_ready) begin
            special_q <= 1'b0;
        end
    end

    assign bus.special_flag = special_q;
`endif

    assign bus.operand_a      = operand_a_q;
    assign bus.operand_b      = operand_b_q;
    assign bus.operands_valid = valid_q;
    assign byte_index         = {state != LOAD_A, idx};

endmodule

// File: tb/tb_float_operand_loader.sv
// Scoreboard bench for float_operand_loader (DEBOUNCE_CYCLES = 4).
module tb_float_operand_loader;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       nenter = 1'b1;
    logic [7:0] inputdata = 8'h00;
    logic [2:0] byte_index;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        f;
    } exp_t;

    exp_t sb[$];
    logic valid_q = 1'b0;

    float_operand_loader_if bus ();

    float_operand_loader #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .nenter    (nenter),
        .inputdata (inputdata),
        .byte_index(byte_index),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic flag_model(input logic [31:0] a, input logic [31:0] b);
`ifdef FLOAT_LOADER_SPECIAL_CHECK_EN
        return (a[30:23] == 8'hFF) | (b[30:23] == 8'hFF);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic dut_flag();
`ifdef FLOAT_LOADER_SPECIAL_CHECK_EN
        return bus.special_flag;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: each new valid presentation is compared against the scoreboard head.
    always @(negedge clk) begin
        if (nreset && bus.operands_valid && !valid_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: valid raised with no expected operands at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_operand_a", bus.operand_a, e.a);
                chk("sb_operand_b", bus.operand_b, e.b);
                chk("sb_special_flag", {31'd0, dut_flag()}, {31'd0, e.f});
            end
        end
        valid_q <= bus.operands_valid;
    end

    // Hold the key low for 'hold' cycles then release; lat = first cycle where
    // byte_index/valid changed (0 if no change seen while held).
    task automatic press(input logic [7:0] b, input int hold, output int lat);
        logic [3:0] prev;
        inputdata = b;
        prev = {byte_index, bus.operands_valid};
        lat = 0;
        nenter = 1'b0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (lat == 0 && {byte_index, bus.operands_valid} != prev) lat = i;
        end
        nenter = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic key_level(input logic lvl, input int cycles);
        nenter = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_operand_a", bus.operand_a, 32'h0);
        chk("rst_operand_b", bus.operand_b, 32'h0);
        chk("rst_valid", {31'd0, bus.operands_valid}, 32'd0);
        chk("rst_byte_index", {29'd0, byte_index}, 32'd0);
        chk("rst_special_flag", {31'd0, dut_flag()}, 32'd0);
        nreset = 1'b1;
        @(negedge clk);
    endtask

    // Enter A then B, checking write latency and slot progress for each byte.
    task automatic load_pair(input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [7:0] byt;
        exp_t e;
        e.a = a;
        e.b = b;
        e.f = flag_model(a, b);
        sb.push_back(e);
        for (int i = 0; i < 8; i++) begin
            byt = (i < 4) ? a[8*i +: 8] : b[8*(i-4) +: 8];
            press(byt, 10, lat);
            chk("write_latency", lat, 7);
            if (i < 7) begin
                chk("byte_index_step", {29'd0, byte_index}, 32'(i + 1));
                chk("valid_low_during_entry", {31'd0, bus.operands_valid}, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.operands_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Clean entry: 1.0 and 2.0, held valid under backpressure.
        load_pair(32'h3F800000, 32'h40000000);
        chk("valid_after_entry", {31'd0, bus.operands_valid}, 32'd1);
        chk("byte_index_valid", {29'd0, byte_index}, 32'h4);

        // Backpressure: presses in VALID must not write.
        press(8'hAA, 10, lat);
        chk("bp_no_write_1", lat, 0);
        press(8'hBB, 10, lat);
        chk("bp_no_write_2", lat, 0);
        press(8'hCC, 10, lat);
        chk("bp_no_write_3", lat, 0);
        chk("bp_operand_a", bus.operand_a, 32'h3F800000);
        chk("bp_operand_b", bus.operand_b, 32'h40000000);
        chk("bp_valid_held", {31'd0, bus.operands_valid}, 32'd1);

        bus.operands_ready = 1'b1;
        @(negedge clk);
        bus.operands_ready = 1'b0;
        chk("xfer_valid_drop", {31'd0, bus.operands_valid}, 32'd0);
        chk("xfer_byte_index", {29'd0, byte_index}, 32'd0);
        chk("xfer_operand_a_kept", bus.operand_a, 32'h3F800000);

        // Glitch of 3 low samples: no write.
        key_level(1'b0, 3);
        key_level(1'b1, 6);
        chk("glitch3_no_write", {29'd0, byte_index}, 32'd0);

        // Bounce: low 2, high 1, low 10 -> one write.
        inputdata = 8'h11;
        key_level(1'b0, 2);
        key_level(1'b1, 1);
        key_level(1'b0, 10);
        key_level(1'b1, 6);
        chk("bounce_one_write", {29'd0, byte_index}, 32'd1);
        chk("bounce_byte", {24'd0, bus.operand_a[7:0]}, 32'h11);

        // Exactly 4 low samples is enough.
        inputdata = 8'h22;
        key_level(1'b0, 4);
        key_level(1'b1, 6);
        chk("low4_write", {29'd0, byte_index}, 32'd2);

        // Long hold -> one write.
        inputdata = 8'h33;
        key_level(1'b0, 40);
        key_level(1'b1, 6);
        chk("long_hold_one_write", {29'd0, byte_index}, 32'd3);

        press(8'h44, 10, lat);
        press(8'h55, 10, lat);
        chk("five_bytes_operand_a", bus.operand_a, 32'h44332211);
        chk("five_bytes_operand_b", bus.operand_b, 32'h40000055);
        chk("five_bytes_index", {29'd0, byte_index}, 32'h5);

        // Reset mid-entry discards everything.
        do_reset();

        // Clean reload; B is a quiet NaN. Ready high early: single-cycle VALID.
        bus.operands_ready = 1'b1;
        load_pair(32'h3F800000, 32'h7FC00000);
        chk("early_ready_back_to_a", {29'd0, byte_index}, 32'd0);
        chk("early_ready_valid_low", {31'd0, bus.operands_valid}, 32'd0);
        chk("flag_low_outside_valid", {31'd0, dut_flag()}, 32'd0);

        // A = B = 1.0: no special value.
        load_pair(32'h3F800000, 32'h3F800000);
        bus.operands_ready = 1'b0;
        @(negedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
